// File: rtl/gpio_capture_pkg.sv
// gpio_capture_pkg: shared types and packing helpers for the GPIO capture block.
// Rev 1.0
`default_nettype none

package gpio_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } capture_state_t;

    // 1/2/4/8-bit samples give 8/4/2/1 samples per packed byte
    function automatic logic [3:0] samples_per_byte(input logic [1:0] num_gpio_sel);
        return 4'd8 >> num_gpio_sel;
    endfunction

    function automatic logic [3:0] field_width(input logic [1:0] num_gpio_sel);
        return 4'd1 << num_gpio_sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/capture_timebase.sv
// capture_timebase: two-stage sample-rate divider, period = (stage1+1) * 2^timestep clocks.
// Rev 1.0
`default_nettype none

module capture_timebase (
    input  logic       clk_100mhz,
    input  logic       rst_n_sync,
    input  logic       clear,
    input  logic [4:0] stage1_count_sel,
    input  logic [2:0] timestep_sel,
    output logic       tick
);

    logic [4:0] stage1_cnt;
    logic [6:0] stage2_cnt;
    logic [6:0] stage2_max;

    assign stage2_max = 7'((8'd1 << timestep_sel) - 8'd1);

    // Tick on the all-zero count so the first cycle after clear is a sample
    assign tick = ~clear && (stage1_cnt == 5'd0) && (stage2_cnt == 7'd0);

    always_ff @(posedge clk_100mhz or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            stage1_cnt <= 5'd0;
            stage2_cnt <= 7'd0;
        end else if (clear) begin
            stage1_cnt <= 5'd0;
            stage2_cnt <= 7'd0;
        end else if (stage1_cnt == stage1_count_sel) begin
            stage1_cnt <= 5'd0;
            stage2_cnt <= (stage2_cnt == stage2_max) ? 7'd0 : stage2_cnt + 7'd1;
        end else begin
            stage1_cnt <= stage1_cnt + 5'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gpio_capture.sv
// gpio_capture: samples 1/2/4/8 GPIO pins on a programmable timebase and packs them into BRAM bytes.
// Rev 1.0
`default_nettype none

module gpio_capture
    import gpio_capture_pkg::*;
#(
    parameter int RAM_ADDR_BITS = 8
) (
    input  logic                     clk_100mhz,
    input  logic                     rst_n_sync,
    input  logic [7:0]               gpio_in,
    input  logic                     trigger_in,
    input  logic                     cfg_enable_cap,
    input  logic                     cfg_wait_trigger_cap,
    input  logic [RAM_ADDR_BITS-1:0] cfg_end_address_cap,
    input  logic [1:0]               cfg_num_gpio_sel_cap,
    input  logic [2:0]               cfg_timestep_sel_cap,
    input  logic [4:0]               cfg_stage1_count_sel_cap,
    output logic                     capture_active,
    output logic                     capture_done,
    output logic                     ram_write_enable,
    output logic [RAM_ADDR_BITS-1:0] ram_addr_cap,
    output logic [7:0]               ram_write_data
);

    capture_state_t           state;
    logic [7:0]               gpio_meta;
    logic [7:0]               gpio_sync;
    logic                     trigger_prev;
    logic                     trigger_edge;

    logic [RAM_ADDR_BITS-1:0] end_address_lat;
    logic [1:0]               num_gpio_sel_lat;
    logic [2:0]               timestep_sel_lat;
    logic [4:0]               stage1_count_sel_lat;

    logic [7:0]               pack_reg;
    logic [2:0]               sample_cnt;
    logic [RAM_ADDR_BITS-1:0] byte_addr;
    logic                     last_write_pending;

    logic                     tick;
    logic                     timebase_clear;
    logic [7:0]               sample_field;
    logic [2:0]               shift_amt;
    logic [7:0]               pack_next;
    logic                     byte_complete;

    always_ff @(posedge clk_100mhz or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            gpio_meta    <= 8'd0;
            gpio_sync    <= 8'd0;
            trigger_prev <= 1'b0;
        end else begin
            gpio_meta    <= gpio_in;
            gpio_sync    <= gpio_meta;
            trigger_prev <= trigger_in;
        end
    end

    assign trigger_edge   = trigger_in & ~trigger_prev;
    assign timebase_clear = (state != CAPTURE);

    capture_timebase u_timebase (
        .clk_100mhz       (clk_100mhz),
        .rst_n_sync       (rst_n_sync),
        .clear            (timebase_clear),
        .stage1_count_sel (stage1_count_sel_lat),
        .timestep_sel     (timestep_sel_lat),
        .tick             (tick)
    );

    always_comb begin
        sample_field = 8'd0;
        case (num_gpio_sel_lat)
            2'd0:    sample_field = {7'd0, gpio_sync[0]};
            2'd1:    sample_field = {6'd0, gpio_sync[1:0]};
            2'd2:    sample_field = {4'd0, gpio_sync[3:0]};
            default: sample_field = gpio_sync;
        endcase
    end

    assign shift_amt     = 3'({1'b0, sample_cnt} * field_width(num_gpio_sel_lat));
    assign pack_next     = pack_reg | (sample_field << shift_amt);
    assign byte_complete = ({1'b0, sample_cnt} == (samples_per_byte(num_gpio_sel_lat) - 4'd1));

    always_ff @(posedge clk_100mhz or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state                <= IDLE;
            capture_active       <= 1'b0;
            capture_done         <= 1'b0;
            ram_write_enable     <= 1'b0;
            ram_addr_cap         <= '0;
            ram_write_data       <= 8'd0;
            end_address_lat      <= '0;
            num_gpio_sel_lat     <= 2'd0;
            timestep_sel_lat     <= 3'd0;
            stage1_count_sel_lat <= 5'd0;
            pack_reg             <= 8'd0;
            sample_cnt           <= 3'd0;
            byte_addr            <= '0;
            last_write_pending   <= 1'b0;
        end else begin
            ram_write_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_enable_cap) begin
                        end_address_lat      <= cfg_end_address_cap;
                        num_gpio_sel_lat     <= cfg_num_gpio_sel_cap;
                        timestep_sel_lat     <= cfg_timestep_sel_cap;
                        stage1_count_sel_lat <= cfg_stage1_count_sel_cap;
                        capture_active       <= 1'b1;
                        pack_reg             <= 8'd0;
                        sample_cnt           <= 3'd0;
                        byte_addr            <= '0;
                        ram_addr_cap         <= '0;
                        last_write_pending   <= 1'b0;
                        state                <= cfg_wait_trigger_cap ? ARMED : CAPTURE;
                    end
                end
                ARMED: begin
                    if (!cfg_enable_cap) begin
                        state          <= IDLE;
                        capture_active <= 1'b0;
                    end else if (trigger_edge) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (!cfg_enable_cap) begin
                        state              <= IDLE;
                        capture_active     <= 1'b0;
                        last_write_pending <= 1'b0;
                    end else if (last_write_pending) begin
                        // Final strobe has been on the bus for one cycle
                        state              <= DONE;
                        capture_active     <= 1'b0;
                        capture_done       <= 1'b1;
                        last_write_pending <= 1'b0;
                    end else if (tick) begin
                        if (byte_complete) begin
                            ram_write_enable <= 1'b1;
                            ram_write_data   <= pack_next;
                            ram_addr_cap     <= byte_addr;
                            byte_addr        <= byte_addr + 1'b1;
                            pack_reg         <= 8'd0;
                            sample_cnt       <= 3'd0;
                            if (byte_addr == end_address_lat) begin
                                last_write_pending <= 1'b1;
                            end
                        end else begin
                            pack_reg   <= pack_next;
                            sample_cnt <= sample_cnt + 3'd1;
                        end
                    end
                end
                DONE: begin
                    if (!cfg_enable_cap) begin
                        state        <= IDLE;
                        capture_done <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gpio_capture.sv
// tb_gpio_capture: directed vectors with a write-strobe scoreboard for gpio_capture.
`default_nettype none

module tb_gpio_capture;

    logic       clk_100mhz;
    logic       rst_n_sync;
    logic [7:0] gpio_in;
    logic       trigger_in;
    logic       cfg_enable_cap;
    logic       cfg_wait_trigger_cap;
    logic [7:0] cfg_end_address_cap;
    logic [1:0] cfg_num_gpio_sel_cap;
    logic [2:0] cfg_timestep_sel_cap;
    logic [4:0] cfg_stage1_count_sel_cap;
    logic       capture_active;
    logic       capture_done;
    logic       ram_write_enable;
    logic [7:0] ram_addr_cap;
    logic [7:0] ram_write_data;

    gpio_capture #(.RAM_ADDR_BITS(8)) dut (
        .clk_100mhz               (clk_100mhz),
        .rst_n_sync               (rst_n_sync),
        .gpio_in                  (gpio_in),
        .trigger_in               (trigger_in),
        .cfg_enable_cap           (cfg_enable_cap),
        .cfg_wait_trigger_cap     (cfg_wait_trigger_cap),
        .cfg_end_address_cap      (cfg_end_address_cap),
        .cfg_num_gpio_sel_cap     (cfg_num_gpio_sel_cap),
        .cfg_timestep_sel_cap     (cfg_timestep_sel_cap),
        .cfg_stage1_count_sel_cap (cfg_stage1_count_sel_cap),
        .capture_active           (capture_active),
        .capture_done             (capture_done),
        .ram_write_enable         (ram_write_enable),
        .ram_addr_cap             (ram_addr_cap),
        .ram_write_data           (ram_write_data)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } exp_write_t;

    exp_write_t sb[$];
    int cyc = 0;
    int pass_count = 0;
    int check_count = 0;

    initial clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    always @(posedge clk_100mhz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input logic [7:0] addr, input logic [7:0] data, input int when);
        exp_write_t e;
        e.addr = addr;
        e.data = data;
        e.cyc  = when;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_100mhz);
            #1;
        end
    endtask

    // Monitor: every strobe must match the head of the expected-write queue
    always @(negedge clk_100mhz) begin
        if (ram_write_enable) begin
            if (sb.size() == 0) begin
                check_count++;
                $display("FAIL unexpected_strobe: addr 0x%0h data 0x%0h at cycle %0d, none expected",
                         ram_addr_cap, ram_write_data, cyc);
            end else begin
                exp_write_t e;
                e = sb.pop_front();
                check("strobe_addr", ram_addr_cap, e.addr);
                check("strobe_data", ram_write_data, e.data);
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int c;
        logic [7:0] pat;

        rst_n_sync = 1'b0;
        gpio_in = 8'd0;
        trigger_in = 1'b0;
        cfg_enable_cap = 1'b0;
        cfg_wait_trigger_cap = 1'b0;
        cfg_end_address_cap = 8'd0;
        cfg_num_gpio_sel_cap = 2'd3;
        cfg_timestep_sel_cap = 3'd0;
        cfg_stage1_count_sel_cap = 5'd0;
        step(3);
        check("rst_active", capture_active, 0);
        check("rst_done", capture_done, 0);
        check("rst_we", ram_write_enable, 0);
        check("rst_addr", ram_addr_cap, 0);
        check("rst_data", ram_write_data, 0);
        rst_n_sync = 1'b1;
        step(2);
        check("idle_active", capture_active, 0);

        // Immediate start, 8-bit ramp, period 1, end 3
        cfg_end_address_cap = 8'd3;
        c = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            gpio_in = 8'h10 + 8'(i);
            if (i == 2) begin
                cfg_enable_cap = 1'b1;
                c = cyc;
                for (int n = 0; n < 4; n++) push(8'(n), 8'h11 + 8'(n), c + 2 + n);
            end
            if (i == 5) check("t1_active_mid", capture_active, 1);
        end
        check("t1_done", capture_done, 1);
        check("t1_active_after", capture_active, 0);
        check("t1_all_strobes", sb.size(), 0);
        cfg_enable_cap = 1'b0;
        step(1);
        check("t1_done_cleared", capture_done, 0);

        // Bit packing, 1-bit mode, end 0; upper pins carry junk
        cfg_num_gpio_sel_cap = 2'd0;
        cfg_end_address_cap = 8'd0;
        pat = 8'h8D;
        for (int i = 0; i < 16; i++) begin
            step(1);
            gpio_in = (i >= 1 && i <= 8) ? {7'h55, pat[i-1]} : 8'hFE;
            if (i == 2) begin
                cfg_enable_cap = 1'b1;
                c = cyc;
                push(8'd0, 8'h8D, c + 9);
            end
        end
        check("t2_done", capture_done, 1);
        check("t2_all_strobes", sb.size(), 0);
        cfg_enable_cap = 1'b0;
        step(2);

        // Timebase period 20, 8-bit, end 1
        cfg_num_gpio_sel_cap = 2'd3;
        cfg_end_address_cap = 8'd1;
        cfg_stage1_count_sel_cap = 5'd4;
        cfg_timestep_sel_cap = 3'd2;
        for (int i = 0; i < 31; i++) begin
            step(1);
            gpio_in = (i < 10) ? 8'h5A : 8'hC3;
            if (i == 2) begin
                cfg_enable_cap = 1'b1;
                c = cyc;
                push(8'd0, 8'h5A, c + 2);
                push(8'd1, 8'hC3, c + 22);
            end
            if (i == 10) cfg_stage1_count_sel_cap = 5'd0;
        end
        check("t3_done", capture_done, 1);
        check("t3_all_strobes", sb.size(), 0);
        cfg_enable_cap = 1'b0;
        cfg_timestep_sel_cap = 3'd0;
        step(2);

        // Trigger already high on arm must not start capture
        cfg_end_address_cap = 8'd0;
        cfg_wait_trigger_cap = 1'b1;
        gpio_in = 8'h3C;
        trigger_in = 1'b1;
        step(2);
        cfg_enable_cap = 1'b1;
        step(6);
        check("t4_armed_active", capture_active, 1);
        check("t4_armed_not_done", capture_done, 0);
        trigger_in = 1'b0;
        step(1);
        trigger_in = 1'b1;
        c = cyc;
        push(8'd0, 8'h3C, c + 2);
        check("t4_active_at_edge", capture_active, 1);
        step(6);
        check("t4_done", capture_done, 1);
        check("t4_all_strobes", sb.size(), 0);
        cfg_enable_cap = 1'b0;
        cfg_wait_trigger_cap = 1'b0;
        trigger_in = 1'b0;
        step(2);

        // Abort after two of eight bytes, then restart from address 0
        cfg_stage1_count_sel_cap = 5'd9;
        cfg_end_address_cap = 8'd7;
        gpio_in = 8'h77;
        for (int i = 0; i < 41; i++) begin
            step(1);
            if (i == 2) begin
                cfg_enable_cap = 1'b1;
                c = cyc;
                push(8'd0, 8'h77, c + 2);
                push(8'd1, 8'h77, c + 12);
            end
            if (i == 18) cfg_enable_cap = 1'b0;
            if (i == 19) check("t5_abort_active", capture_active, 0);
        end
        check("t5_two_strobes", sb.size(), 0);
        cfg_stage1_count_sel_cap = 5'd0;
        cfg_end_address_cap = 8'd1;
        step(1);
        cfg_enable_cap = 1'b1;
        c = cyc;
        push(8'd0, 8'h77, c + 2);
        push(8'd1, 8'h77, c + 3);
        step(7);
        check("t5_restart_done", capture_done, 1);
        check("t5_restart_strobes", sb.size(), 0);
        cfg_enable_cap = 1'b0;
        step(2);

        // Asynchronous reset in the middle of a capture
        cfg_stage1_count_sel_cap = 5'd9;
        cfg_end_address_cap = 8'd7;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (i == 2) begin
                cfg_enable_cap = 1'b1;
                c = cyc;
                push(8'd0, 8'h77, c + 2);
                push(8'd1, 8'h77, c + 12);
            end
        end
        check("t6_active_before", capture_active, 1);
        #2;
        rst_n_sync = 1'b0;
        cfg_enable_cap = 1'b0;
        #1;
        check("t6_rst_active", capture_active, 0);
        check("t6_rst_done", capture_done, 0);
        check("t6_rst_we", ram_write_enable, 0);
        check("t6_rst_addr", ram_addr_cap, 0);
        check("t6_rst_data", ram_write_data, 0);
        step(2);
        rst_n_sync = 1'b1;
        step(3);
        check("t6_idle_after", capture_active, 0);
        check("t6_strobes_before_rst", sb.size(), 0);
        cfg_stage1_count_sel_cap = 5'd0;
        cfg_end_address_cap = 8'd0;
        cfg_enable_cap = 1'b1;
        c = cyc;
        push(8'd0, 8'h77, c + 2);
        step(1);
        check("t6_reenable_active", capture_active, 1);
        step(4);
        check("t6_reenable_done", capture_done, 1);
        cfg_enable_cap = 1'b0;
        step(2);
        check("final_all_strobes", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

`default_nettype wire
